i2c_target_regs: RTL and testbench
==================================

Name: i2c_target_regs

Overview:
- I2C target (slave) responder: the other end of the bus from the on-board I2C master used for the external IMU.
- Exposes a byte-wide register file to an external I2C host, such as a ground-station bridge or a second flight board.
- Sits on the CPU bus as a 32-bit peripheral (WE/DATA_IN/DATA_OUT). The CPU pre-loads telemetry bytes and collects host-written command bytes.

Parameters:
- TARGET_ADDR, 7'h42, 7-bit I2C address this block answers to.
- NREGS, 16, number of 8-bit registers; must be a power of 2 (2..256). PTR_W = log2(NREGS).
- TIMEOUT_CYC, 50000, CLK cycles of SCL held low before the bus is abandoned (only with I2C_TIMEOUT_EN).

Ports:
- CLK  in  1  system clock (CPU clock domain).
- RESET  in  1  asynchronous, active-high reset.
- WE  in  1  CPU write strobe, one CLK cycle.
- DATA_IN  in  32  CPU write word:
  - [31] = load register; [15:8] = register index (low PTR_W bits used); [7:0] = data.
  - [30] = clear event flag.
- DATA_OUT  out  32  status word:
  - [7:0] = last host-written byte; [15:8] = its index.
  - [16] = host-write event (sticky); [17] = addressed/busy; [18] = last transfer ended with NACK.
  - [19] = timeout occurred (sticky; 0 when feature is off). Other bits are 0.
- SCL  in  1  I2C clock. No clock stretching.
- SDA  inout  1  I2C data, open-drain: driven 0 when sda_oe=1, otherwise Z.

Behaviour:
- Reset: every register-file byte is 0; pointer is 0; sda_oe is 0; FSM is IDLE; DATA_OUT is 0.
- Input conditioning:
  - SCL and SDA each pass through a 2-FF synchronizer (sync init 1) and a 1-cycle-delayed copy for edge detection.
  - START = SDA falling while SCL high. STOP = SDA rising while SCL high.
  - The START/STOP check takes priority over data-edge handling in the same cycle.
- Bit timing:
  - Receive bits are sampled on a synced SCL rising edge.
  - Transmit bits and ACK are changed on a synced SCL falling edge.
  - SCL high and low phases must each be at least 4 CLK cycles.
- FSM states: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK, IGNORE.
  - START (or repeated START) from any state -> ADDR; bit count = 0.
  - STOP from any state -> IDLE; sda_oe = 0.
  - ADDR: shift in 8 bits, MSB first.
    - On the 8th-bit SCL fall: if addr[7:1] == TARGET_ADDR, set sda_oe = 1 and go to ADDR_ACK; otherwise go to IGNORE.
  - ADDR_ACK: on the next SCL fall, release SDA.
    - R/W = 0 -> PTR.
    - R/W = 1 -> load shifter with reg[ptr], drive bit7 (sda_oe = ~bit), go to RDATA.
  - PTR: 8 bits; ptr = byte[PTR_W-1:0]; ACK -> PTR_ACK -> WDATA.
  - WDATA: 8 bits, then ACK.
    - reg[ptr] = byte; event[16] = 1; DATA_OUT[15:0] = {ptr, byte}.
    - ptr = ptr + 1, wrapping NREGS-1 -> 0.
    - Go to WDATA_ACK -> WDATA.
  - RDATA: after 8 bits released, set ptr = ptr + 1 (wraps) and release SDA -> RACK.
  - RACK: sample the host bit on SCL rise.
    - 0 (ACK): at SCL fall, load reg[ptr], drive its MSB -> RDATA.
    - 1 (NACK): set [18] = 1 -> IGNORE.
  - IGNORE: sda_oe = 0; wait for START/STOP.
- Read data is snapshotted into the shifter at load time. A later CPU write does not alter the byte in flight.
- Busy [17] = 1 in every state except IDLE and IGNORE.
- [18] is cleared at the next address match.
- Simultaneous CPU load and host write to the same index in the same cycle: the host write wins. Different indices: both take effect.
- CPU clear [30] together with a host-write event in the same cycle: the event wins (flag stays 1).
- RESET asserted mid-transfer: SDA is released immediately (asynchronous); the block ignores the bus until the next START.

Optional Feature:
- Macro I2C_TIMEOUT_EN.
- Defined: a counter runs while the synced SCL is low and the FSM is not IDLE/IGNORE.
  - When it reaches TIMEOUT_CYC: sda_oe = 0, FSM -> IDLE, [19] = 1.
  - [19] is cleared by the CPU [30] clear.
- Not defined: no counter; [19] reads 0; the FSM only leaves a transfer on START/STOP/RESET.

Decomposition:
- Shared package i2c_pkg holds:
  - the FSM state enum;
  - status bit positions (EVT_BIT = 16, BUSY_BIT = 17, NACK_BIT = 18, TO_BIT = 19);
  - DATA_IN field positions (LOAD_BIT = 31, CLR_BIT = 30);
  - the synchronizer depth constant.
- One sub-module, i2c_line_cond: synchronizers plus edge/START/STOP detection for SCL/SDA. It is reusable by the existing I2C master.

Test Plan:
- Host write: START, 0x84 (addr 0x42, W), 0x03, 0xA5, 0x5A, STOP -> all ACKed; reg[3] = 0xA5, reg[4] = 0x5A; DATA_OUT = 0x0001045A.
- Host read with wrap: CPU loads reg[15] = 0xC3 and reg[0] = 0x11. Host writes ptr 0x0F, sends repeated START, then 0x85, reads 2 bytes (ACK, then NACK) -> bytes 0xC3, 0x11; [18] = 1; ptr = 1.
- Wrong address: START, 0x90, ... -> SDA never driven low; no register changes; [17] = 0.
- Collision: CPU loads reg[3] = 0x77 in the same CLK cycle the host byte 0x99 commits to reg[3] -> reg[3] = 0x99. Event clear in the same cycle -> [16] stays 1.
- Reset mid-read: assert RESET while the target drives a 0 bit -> SDA = Z within the same cycle; the next full transaction succeeds.
- I2C_TIMEOUT_EN: after the address ACK, hold SCL low for TIMEOUT_CYC + 1 cycles -> SDA released, [19] = 1, FSM IDLE. The next START/0x84 is ACKed.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C target register block: FSM states,
// status/command bit positions and synchronizer depth.
package i2c_pkg;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        PTR,
        PTR_ACK,
        WDATA,
        WDATA_ACK,
        RDATA,
        RACK,
        IGNORE
    } i2c_state_t;

    localparam int unsigned EVT_BIT  = 16;
    localparam int unsigned BUSY_BIT = 17;
    localparam int unsigned NACK_BIT = 18;
    localparam int unsigned TO_BIT   = 19;

    localparam int unsigned LOAD_BIT = 31;
    localparam int unsigned CLR_BIT  = 30;

    localparam int unsigned SYNC_DEPTH = 2;

    function automatic logic is_busy(input i2c_state_t s);
        return !(s == IDLE || s == IGNORE);
    endfunction

endpackage

// File: rtl/i2c_line_cond.sv
// SCL/SDA conditioning: synchronizers (idle-high init), delayed copies,
// SCL edge strobes and START/STOP detection. Shared with the I2C master.
module i2c_line_cond
    import i2c_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic scl,
    input  logic sda,
    output logic scl_s,
    output logic sda_s,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [SYNC_DEPTH-1:0] scl_sync;
    logic [SYNC_DEPTH-1:0] sda_sync;
    logic                  scl_prev;
    logic                  sda_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_DEPTH-2:0], scl};
            sda_sync <= {sda_sync[SYNC_DEPTH-2:0], sda};
            scl_prev <= scl_sync[SYNC_DEPTH-1];
            sda_prev <= sda_sync[SYNC_DEPTH-1];
        end
    end

    assign scl_s     = scl_sync[SYNC_DEPTH-1];
    assign sda_s     = sda_sync[SYNC_DEPTH-1];
    assign scl_rise  = scl_s & ~scl_prev;
    assign scl_fall  = ~scl_s & scl_prev;
    // Bus conditions are qualified on the current synced SCL only.
    assign start_det = scl_s & sda_prev & ~sda_s;
    assign stop_det  = scl_s & ~sda_prev & sda_s;

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target exposing an NREGS x 8-bit register file to an external host,
// with a CPU-side load/clear/status port. Optional macro: I2C_TIMEOUT_EN.
module i2c_target_regs
    import i2c_pkg::*;
#(
    parameter logic [6:0]  TARGET_ADDR = 7'h42,
    parameter int unsigned NREGS       = 16,
    parameter int unsigned TIMEOUT_CYC = 50000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        WE,
    input  logic [31:0] DATA_IN,
    output logic [31:0] DATA_OUT,
    input  logic        SCL,
    inout  wire         SDA
);

    localparam int unsigned PTR_W = $clog2(NREGS);

    if (NREGS < 2 || NREGS > 256 || (NREGS & (NREGS - 1)) != 0 || TIMEOUT_CYC == 0) begin : g_param_check
        $error("i2c_target_regs: invalid NREGS or TIMEOUT_CYC");
    end

    logic scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;

    i2c_line_cond u_line_cond (
        .clk       (CLK),
        .rst       (RESET),
        .scl       (SCL),
        .sda       (SDA),
        .scl_s     (scl_s),
        .sda_s     (sda_s),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    i2c_state_t       state;
    logic [3:0]       bit_cnt;
    logic [7:0]       shifter;
    logic             sda_oe;
    logic             rw;
    logic [PTR_W-1:0] ptr;
    logic [7:0]       regs [NREGS];
    logic [7:0]       last_byte;
    logic [PTR_W-1:0] last_idx;
    logic             evt_flag;
    logic             nack_flag;
    logic             to_flag;
    logic             unused_bits;

`ifdef I2C_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0] to_cnt;
    logic            to_run;
    logic            to_hit;
    assign to_run = is_busy(state) && !scl_s;
    assign to_hit = to_run && (to_cnt == TO_W'(TIMEOUT_CYC - 1));
`endif

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shifter   <= '0;
            sda_oe    <= 1'b0;
            rw        <= 1'b0;
            ptr       <= '0;
            last_byte <= '0;
            last_idx  <= '0;
            evt_flag  <= 1'b0;
            nack_flag <= 1'b0;
            to_flag   <= 1'b0;
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
`ifdef I2C_TIMEOUT_EN
            to_cnt    <= '0;
`endif
        end else begin
            // CPU side first so that a host commit later in this block wins.
            if (WE) begin
                if (DATA_IN[LOAD_BIT]) begin
                    regs[DATA_IN[8 +: PTR_W]] <= DATA_IN[7:0];
                end
                if (DATA_IN[CLR_BIT]) begin
                    evt_flag <= 1'b0;
                    to_flag  <= 1'b0;
                end
            end
`ifdef I2C_TIMEOUT_EN
            to_cnt <= to_run ? to_cnt + 1'b1 : '0;
`endif
            if (start_det) begin
                state   <= ADDR;
                bit_cnt <= '0;
                sda_oe  <= 1'b0;
            end else if (stop_det) begin
                state  <= IDLE;
                sda_oe <= 1'b0;
`ifdef I2C_TIMEOUT_EN
            end else if (to_hit) begin
                state   <= IDLE;
                sda_oe  <= 1'b0;
                to_flag <= 1'b1;
`endif
            end else begin
                case (state)
                    ADDR, PTR, WDATA: begin
                        if (scl_rise) begin
                            shifter <= {shifter[6:0], sda_s};
                            bit_cnt <= bit_cnt + 1'b1;
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            bit_cnt <= '0;
                            if (state == ADDR) begin
                                if (shifter[7:1] == TARGET_ADDR) begin
                                    rw        <= shifter[0];
                                    nack_flag <= 1'b0;
                                    sda_oe    <= 1'b1;
                                    state     <= ADDR_ACK;
                                end else begin
                                    state <= IGNORE;
                                end
                            end else if (state == PTR) begin
                                ptr    <= shifter[PTR_W-1:0];
                                sda_oe <= 1'b1;
                                state  <= PTR_ACK;
                            end else begin
                                regs[ptr] <= shifter;
                                evt_flag  <= 1'b1;
                                last_byte <= shifter;
                                last_idx  <= ptr;
                                ptr       <= ptr + 1'b1;
                                sda_oe    <= 1'b1;
                                state     <= WDATA_ACK;
                            end
                        end
                    end
                    ADDR_ACK: begin
                        if (scl_fall) begin
                            bit_cnt <= '0;
                            if (rw) begin
                                shifter <= regs[ptr];
                                sda_oe  <= ~regs[ptr][7];
                                state   <= RDATA;
                            end else begin
                                sda_oe <= 1'b0;
                                state  <= PTR;
                            end
                        end
                    end
                    PTR_ACK, WDATA_ACK: begin
                        if (scl_fall) begin
                            sda_oe  <= 1'b0;
                            bit_cnt <= '0;
                            state   <= WDATA;
                        end
                    end
                    RDATA: begin
                        if (scl_rise) begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end else if (scl_fall) begin
                            if (bit_cnt == 4'd8) begin
                                sda_oe  <= 1'b0;
                                ptr     <= ptr + 1'b1;
                                bit_cnt <= '0;
                                state   <= RACK;
                            end else begin
                                shifter <= {shifter[6:0], 1'b0};
                                sda_oe  <= ~shifter[6];
                            end
                        end
                    end
                    RACK: begin
                        if (scl_rise && sda_s) begin
                            nack_flag <= 1'b1;
                            state     <= IGNORE;
                        end else if (scl_fall) begin
                            shifter <= regs[ptr];
                            sda_oe  <= ~regs[ptr][7];
                            bit_cnt <= '0;
                            state   <= RDATA;
                        end
                    end
                    IGNORE: begin
                        sda_oe <= 1'b0;
                    end
                    default: begin
                        sda_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign SDA = sda_oe ? 1'b0 : 1'bz;

    always_comb begin
        DATA_OUT              = '0;
        DATA_OUT[7:0]         = last_byte;
        DATA_OUT[8 +: PTR_W]  = last_idx;
        DATA_OUT[EVT_BIT]     = evt_flag;
        DATA_OUT[BUSY_BIT]    = is_busy(state);
        DATA_OUT[NACK_BIT]    = nack_flag;
`ifdef I2C_TIMEOUT_EN
        DATA_OUT[TO_BIT]      = to_flag;
`else
        DATA_OUT[TO_BIT]      = 1'b0;
`endif
    end

    assign unused_bits = ^{DATA_IN, scl_s, to_flag};

endmodule

// File: tb/tb_i2c_target_regs.sv
// Scoreboard bench for i2c_target_regs: the host model queues expected ACKs,
// read bytes, SDA levels and status words; monitors pop and compare.
module tb_i2c_target_regs;
    import i2c_pkg::*;

    localparam int          Q         = 100;
    localparam int unsigned TO_CYC    = 200;
    localparam logic [31:0] COLL_WORD = 32'hC000_0377;

    typedef enum int {K_ACK, K_BYTE, K_STATUS, K_LINE} kind_t;
    typedef struct {
        kind_t       kind;
        string       name;
        logic [31:0] exp;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        scl;
    logic        host_sda;
    wire         sda_bus;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   listen_kind = 0;
    int   mon_lk;
    int   rx_bits = 0;
    logic [7:0] rx_byte = '0;
    event status_req;
    event line_req;

    pullup (sda_bus);
    assign sda_bus = host_sda ? 1'bz : 1'b0;

    always #5 clk = ~clk;

    i2c_target_regs #(
        .TARGET_ADDR (7'h42),
        .NREGS       (16),
        .TIMEOUT_CYC (TO_CYC)
    ) dut (
        .CLK      (clk),
        .RESET    (rst),
        .WE       (we),
        .DATA_IN  (data_in),
        .DATA_OUT (data_out),
        .SCL      (scl),
        .SDA      (sda_bus)
    );

    task automatic push(input kind_t k, input string nm, input logic [31:0] e);
        exp_t x;
        x.kind = k;
        x.name = nm;
        x.exp  = e;
        sb.push_back(x);
    endtask

    task automatic pop_compare(input kind_t k, input logic [31:0] act);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_output: got %h with nothing expected", act);
        end else begin
            e = sb.pop_front();
            if (e.kind != k) begin
                errors++;
                $display("FAIL %s: observed kind %0d, expected kind %0d", e.name, k, e.kind);
            end else if (act !== e.exp) begin
                errors++;
                $display("FAIL %s: got %h, expected %h", e.name, act, e.exp);
            end
        end
    endtask

    // Bus monitor: samples SDA in the middle of every SCL high phase the host listens to.
    always @(posedge scl) begin
        mon_lk = listen_kind;
        if (mon_lk != 0) begin
            #(Q);
            if (mon_lk == 2) begin
                rx_byte = {rx_byte[6:0], sda_bus};
                rx_bits++;
                if (rx_bits == 8) begin
                    rx_bits = 0;
                    pop_compare(K_BYTE, {24'b0, rx_byte});
                end
            end else begin
                pop_compare(K_ACK, {31'b0, sda_bus});
            end
        end
    end

    always @(status_req) pop_compare(K_STATUS, data_out);
    always @(line_req)   pop_compare(K_LINE, {31'b0, sda_bus});

    task automatic check_status(input string nm, input logic [31:0] e);
        push(K_STATUS, nm, e);
        ->status_req;
        #10;
    endtask

    task automatic check_line(input string nm, input logic e);
        push(K_LINE, nm, {31'b0, e});
        ->line_req;
        #10;
    endtask

    task automatic cpu_write(input logic [31:0] w);
        @(negedge clk);
        we      = 1'b1;
        data_in = w;
        @(negedge clk);
        we      = 1'b0;
        data_in = '0;
    endtask

    task automatic clock_bit(input logic b, input int lk);
        host_sda = b;
        #(Q);
        listen_kind = lk;
        scl = 1'b1;
        #(2 * Q);
        scl = 1'b0;
        listen_kind = 0;
        #(Q);
    endtask

    task automatic i2c_start();
        host_sda = 1'b1;
        #(Q);
        scl = 1'b1;
        #(Q);
        host_sda = 1'b0;
        #(Q);
        scl = 1'b0;
        #(Q);
    endtask

    task automatic i2c_stop();
        host_sda = 1'b0;
        #(Q);
        scl = 1'b1;
        #(Q);
        host_sda = 1'b1;
        #(Q);
    endtask

    // collide: the CPU load/clear lands in the exact cycle the 8th bit commits.
    task automatic write_byte(input logic [7:0] d, input logic exp_ack, input string nm, input logic collide);
        push(K_ACK, nm, {31'b0, exp_ack});
        for (int i = 7; i >= 0; i--) begin
            host_sda = d[i];
            #(Q);
            scl = 1'b1;
            #(2 * Q);
            scl = 1'b0;
            if (collide && i == 0) begin
                @(posedge clk);
                @(posedge clk);
                @(negedge clk);
                we      = 1'b1;
                data_in = COLL_WORD;
                @(negedge clk);
                we      = 1'b0;
                data_in = '0;
            end
            #(Q);
        end
        clock_bit(1'b1, 1);
    endtask

    task automatic read_byte(input logic [7:0] e, input logic host_ack, input string nm);
        push(K_BYTE, nm, {24'b0, e});
        for (int i = 0; i < 8; i++) clock_bit(1'b1, 2);
        clock_bit(host_ack, 0);
    endtask

    initial begin
        #(1_000_000);
        $display("FAIL watchdog: simulation did not complete, %0d expected entries pending", sb.size());
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t e;
        rst = 1'b1; we = 1'b0; data_in = '0; scl = 1'b1; host_sda = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_status("reset_status", 32'h0000_0000);

        // Host write of two bytes starting at index 3
        i2c_start();
        write_byte(8'h84, 1'b0, "wr_addr_ack", 1'b0);
        write_byte(8'h03, 1'b0, "wr_ptr_ack", 1'b0);
        write_byte(8'hA5, 1'b0, "wr_d0_ack", 1'b0);
        write_byte(8'h5A, 1'b0, "wr_d1_ack", 1'b0);
        check_status("wr_busy_status", 32'h0003_045A);
        i2c_stop();
        check_status("wr_done_status", 32'h0001_045A);

        // Read the bytes back
        i2c_start();
        write_byte(8'h84, 1'b0, "rb_addr_ack", 1'b0);
        write_byte(8'h03, 1'b0, "rb_ptr_ack", 1'b0);
        i2c_start();
        write_byte(8'h85, 1'b0, "rb_raddr_ack", 1'b0);
        read_byte(8'hA5, 1'b0, "rb_reg3");
        read_byte(8'h5A, 1'b1, "rb_reg4");
        i2c_stop();
        check_status("rb_nack_status", 32'h0005_045A);

        // CPU clear, CPU preload, read across the wrap point
        cpu_write(32'h4000_0000);
        check_status("clear_status", 32'h0004_045A);
        cpu_write(32'h8000_0FC3);
        cpu_write(32'h8000_0011);
        cpu_write(32'h8000_012B);
        i2c_start();
        write_byte(8'h84, 1'b0, "wrap_addr_ack", 1'b0);
        write_byte(8'h0F, 1'b0, "wrap_ptr_ack", 1'b0);
        i2c_start();
        write_byte(8'h85, 1'b0, "wrap_raddr_ack", 1'b0);
        read_byte(8'hC3, 1'b0, "wrap_reg15");
        read_byte(8'h11, 1'b1, "wrap_reg0");
        i2c_stop();
        check_status("wrap_status", 32'h0004_045A);
        i2c_start();
        write_byte(8'h85, 1'b0, "ptr1_raddr_ack", 1'b0);
        read_byte(8'h2B, 1'b1, "ptr1_reg1");
        i2c_stop();

        // Wrong address: never acknowledged, never busy
        i2c_start();
        write_byte(8'h90, 1'b1, "wrong_addr_nack", 1'b0);
        write_byte(8'h12, 1'b1, "wrong_data_nack", 1'b0);
        check_status("wrong_idle_status", 32'h0004_045A);
        i2c_stop();
        check_status("wrong_after_status", 32'h0004_045A);

        // Collision: CPU load + clear in the host commit cycle
        i2c_start();
        write_byte(8'h84, 1'b0, "coll_addr_ack", 1'b0);
        write_byte(8'h03, 1'b0, "coll_ptr_ack", 1'b0);
        write_byte(8'h99, 1'b0, "coll_data_ack", 1'b1);
        i2c_stop();
        check_status("coll_status", 32'h0001_0399);
        i2c_start();
        write_byte(8'h84, 1'b0, "collrb_addr_ack", 1'b0);
        write_byte(8'h03, 1'b0, "collrb_ptr_ack", 1'b0);
        i2c_start();
        write_byte(8'h85, 1'b0, "collrb_raddr_ack", 1'b0);
        read_byte(8'h99, 1'b1, "collrb_reg3");
        i2c_stop();
        check_status("collrb_status", 32'h0005_0399);

        // Reset while the target drives a 0 data bit
        cpu_write(32'h8000_053C);
        i2c_start();
        write_byte(8'h84, 1'b0, "rst_addr_ack", 1'b0);
        write_byte(8'h05, 1'b0, "rst_ptr_ack", 1'b0);
        i2c_start();
        write_byte(8'h85, 1'b0, "rst_raddr_ack", 1'b0);
        check_line("rst_target_drives0", 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        ->line_req;
        push(K_LINE, "rst_sda_released", 32'h1);
        #9;
        check_status("rst_mid_status", 32'h0000_0000);
        @(negedge clk);
        rst = 1'b0;
        scl = 1'b1;
        #(Q);
        i2c_start();
        write_byte(8'h84, 1'b0, "post_addr_ack", 1'b0);
        write_byte(8'h07, 1'b0, "post_ptr_ack", 1'b0);
        write_byte(8'hE1, 1'b0, "post_data_ack", 1'b0);
        i2c_stop();
        check_status("post_status", 32'h0001_07E1);
        i2c_start();
        write_byte(8'h84, 1'b0, "postrb_addr_ack", 1'b0);
        write_byte(8'h07, 1'b0, "postrb_ptr_ack", 1'b0);
        i2c_start();
        write_byte(8'h85, 1'b0, "postrb_raddr_ack", 1'b0);
        read_byte(8'hE1, 1'b1, "postrb_reg7");
        i2c_stop();
        check_status("postrb_status", 32'h0005_07E1);

`ifdef I2C_TIMEOUT_EN
        // SCL held low after the address ACK
        i2c_start();
        write_byte(8'h84, 1'b0, "to_addr_ack", 1'b0);
        #((TO_CYC + 10) * 10);
        check_status("to_status", 32'h0009_07E1);
        check_line("to_sda_released", 1'b1);
        scl = 1'b1;
        #(Q);
        i2c_start();
        write_byte(8'h84, 1'b0, "to_next_addr_ack", 1'b0);
        i2c_stop();
        cpu_write(32'h4000_0000);
        check_status("to_cleared_status", 32'h0000_07E1);
`endif

        #(4 * Q);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            errors++;
            $display("FAIL %s: expected %h was never observed", e.name, e.exp);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
